led_share_ctrl: RTL and testbench



---
 rtl/led_share_ctrl_pkg.sv | 24 ++
 rtl/led_share_ctrl_if.sv | 15 +
 rtl/led_share_ctrl_arb.sv | 28 ++
 rtl/led_share_ctrl.sv | 124 ++++++++++++
 tb/tb_led_share_ctrl.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/led_share_ctrl_pkg.sv
// Shared definitions for the LED-sharing controller: mode codes, FSM states
// and the per-LED pattern decode.
package led_pkg;

  localparam logic [1:0] LED_OFF  = 2'b00;
  localparam logic [1:0] LED_ON   = 2'b01;
  localparam logic [1:0] LED_SLOW = 2'b10;
  localparam logic [1:0] LED_FAST = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_e;

  function automatic logic led_decode(input logic [1:0] md, input logic slow, input logic fast);
    case (md)
      LED_OFF:  return 1'b0;
      LED_ON:   return 1'b1;
      LED_SLOW: return slow;
      default:  return fast;
    endcase
  endfunction

endpackage

// File: rtl/led_share_ctrl_if.sv
// Requester-side bundle of the LED-sharing controller. Handshake: req is a
// level held by a requester; it owns the LEDs while its grant bit is high.
interface led_share_ctrl_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req;
  logic [4*N_REQ-1:0] mode;
  logic [N_REQ-1:0]   grant;
  logic               busy;
  logic               led_0;
  logic               led_1;

  modport master (output req, mode, input grant, busy, led_0, led_1);
  modport slave  (input req, mode, output grant, busy, led_0, led_1);
endinterface

// File: rtl/led_share_ctrl_arb.sv
// Combinational round-robin pick: first requester at or after ptr_i, cyclically.
module led_rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req_i,
  input  logic [$clog2(N_REQ)-1:0] ptr_i,
  output logic [N_REQ-1:0]         winner_o,
  output logic                     any_req_o
);
  localparam int PW = $clog2(N_REQ);

  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    winner_o = '0;
    found    = 1'b0;
    idx      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = PW'((int'(ptr_i) + k) % N_REQ);
      if (!found && req_i[idx]) begin
        winner_o[idx] = 1'b1;
        found         = 1'b1;
      end
    end
    any_req_o = |req_i;
  end
endmodule

// File: rtl/led_share_ctrl.sv
// Round-robin owner of the two board LEDs with min/max hold time and blink modes.
// Optional: define LED_ACTIVE_LOW_EN to invert led_0/led_1 at the output register.
module led_share_ctrl
  import led_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int DIV_W    = 24,
  parameter int SLOW_BIT = 23,
  parameter int FAST_BIT = 21,
  parameter int HOLD_W   = 26,
  parameter int MIN_HOLD = 25_000_000,
  parameter int MAX_HOLD = 50_000_000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  led_share_ctrl_if.slave          bus,
  output state_e                   dbg_state_o,
  output logic [$clog2(N_REQ)-1:0] dbg_rr_ptr_o
);
  localparam int PW = $clog2(N_REQ);

`ifdef LED_ACTIVE_LOW_EN
  localparam logic LED_INV = 1'b1;
`else
  localparam logic LED_INV = 1'b0;
`endif

  state_e            state_q;
  logic [N_REQ-1:0]  grant_q;
  logic              busy_q;
  logic              led0_q, led1_q;
  logic [DIV_W-1:0]  div_q;
  logic [HOLD_W-1:0] hold_q;
  logic [PW-1:0]     rr_q;
  logic [3:0]        mode_q;

  logic [PW-1:0]    owner_idx, next_ptr, arb_ptr;
  logic [N_REQ-1:0] winner;
  logic             any_req;
  logic [3:0]       win_mode, owner_mode;
  logic             owner_req, others, handover;
  logic             led0_d, led1_d;

  // In OWN the search starts just past the owner, so the owner is picked last.
  always_comb begin
    owner_idx  = '0;
    win_mode   = '0;
    owner_mode = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant_q[k]) owner_idx = PW'(k);
      if (winner[k])  win_mode   = bus.mode[4*k +: 4];
      if (grant_q[k]) owner_mode = bus.mode[4*k +: 4];
    end
    next_ptr  = (owner_idx == PW'(N_REQ - 1)) ? '0 : owner_idx + 1'b1;
    arb_ptr   = (state_q == OWN) ? next_ptr : rr_q;
    owner_req = |(bus.req & grant_q);
    others    = |(bus.req & ~grant_q);
    handover  = (!owner_req && (hold_q >= HOLD_W'(MIN_HOLD - 1))) ||
                (others && (hold_q >= HOLD_W'(MAX_HOLD - 1)));
    led0_d    = (state_q == OWN) ? led_decode(mode_q[1:0], div_q[SLOW_BIT], div_q[FAST_BIT]) : 1'b0;
    led1_d    = (state_q == OWN) ? led_decode(mode_q[3:2], div_q[SLOW_BIT], div_q[FAST_BIT]) : 1'b0;
  end

  led_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req_i     (bus.req),
    .ptr_i     (arb_ptr),
    .winner_o  (winner),
    .any_req_o (any_req)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      busy_q  <= 1'b0;
      led0_q  <= LED_INV;
      led1_q  <= LED_INV;
      div_q   <= '0;
      hold_q  <= '0;
      rr_q    <= '0;
      mode_q  <= '0;
    end else begin
      div_q  <= div_q + 1'b1;
      led0_q <= led0_d ^ LED_INV;
      led1_q <= led1_d ^ LED_INV;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            state_q <= OWN;
            grant_q <= winner;
            busy_q  <= 1'b1;
            hold_q  <= '0;
            mode_q  <= win_mode;
          end
        end
        OWN: begin
          if (handover) begin
            rr_q <= next_ptr;
            if (others) begin
              grant_q <= winner;
              hold_q  <= '0;
              mode_q  <= win_mode;
            end else begin
              state_q <= IDLE;
              grant_q <= '0;
              busy_q  <= 1'b0;
            end
          end else begin
            if (hold_q != '1) hold_q <= hold_q + 1'b1;
            if (owner_req)    mode_q <= owner_mode;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.grant    = grant_q;
  assign bus.busy     = busy_q;
  assign bus.led_0    = led0_q;
  assign bus.led_1    = led1_q;
  assign dbg_state_o  = state_q;
  assign dbg_rr_ptr_o = rr_q;
endmodule

// File: tb/tb_led_share_ctrl.sv
// Bench for led_share_ctrl: directed scenarios then random requests, each cycle
// compared against an ownership model kept in terms of owner/age/pointer.
module tb_led_share_ctrl;
  import led_pkg::*;

  localparam int N      = 4;
  localparam int DIV_W  = 4;
  localparam int SLOW   = 3;
  localparam int FAST   = 1;
  localparam int HOLD_W = 8;
  localparam int MIN_H  = 4;
  localparam int MAX_H  = 10;
  localparam int W      = 10;

`ifdef LED_ACTIVE_LOW_EN
  localparam logic INV = 1'b1;
`else
  localparam logic INV = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  led_share_ctrl_if #(.N_REQ(N)) bus ();
  state_e     dbg_state;
  logic [1:0] dbg_rr;

  led_share_ctrl #(
    .N_REQ(N), .DIV_W(DIV_W), .SLOW_BIT(SLOW), .FAST_BIT(FAST),
    .HOLD_W(HOLD_W), .MIN_HOLD(MIN_H), .MAX_HOLD(MAX_H)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .dbg_state_o  (dbg_state),
    .dbg_rr_ptr_o (dbg_rr)
  );

  // scoreboard
  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // reference model: owner (-1 = none), age = cycles owned including the grant cycle
  int         m_owner = -1;
  int         m_age   = 0;
  int         m_ptr   = 0;
  int         m_cycle = 0;
  logic [3:0] m_mode  = '0;
  logic       m_led0  = INV;
  logic       m_led1  = INV;

  function automatic logic pattern(input logic [1:0] md, input int cyc);
    case (md)
      2'd0:    return 1'b0;
      2'd1:    return 1'b1;
      2'd2:    return logic'((cyc >> SLOW) & 1);
      default: return logic'((cyc >> FAST) & 1);
    endcase
  endfunction

  function automatic int first_from(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (((r >> ((p + k) % N)) & 1) != 0) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic model_edge(input logic rst_v, input logic [N-1:0] r, input logic [4*N-1:0] m);
    logic [N-1:0] g;
    bit others, own_req;
    if (!rst_v) begin
      m_owner = -1; m_age = 0; m_ptr = 0; m_cycle = 0; m_mode = '0;
      m_led0 = INV; m_led1 = INV;
    end else begin
      m_led0 = (m_owner >= 0 ? pattern(m_mode[1:0], m_cycle) : 1'b0) ^ INV;
      m_led1 = (m_owner >= 0 ? pattern(m_mode[3:2], m_cycle) : 1'b0) ^ INV;
      if (m_owner < 0) begin
        if (r != 0) begin
          m_owner = first_from(r, m_ptr);
          m_age   = 1;
          m_mode  = m[4*m_owner +: 4];
        end
      end else begin
        own_req = ((r >> m_owner) & 1) != 0;
        others  = (r & ~(N'(1) << m_owner)) != 0;
        if ((!own_req && m_age >= MIN_H) || (others && m_age >= MAX_H)) begin
          m_ptr = (m_owner + 1) % N;
          if (others) begin
            m_owner = first_from(r, m_ptr);
            m_age   = 1;
            m_mode  = m[4*m_owner +: 4];
          end else begin
            m_owner = -1;
          end
        end else begin
          m_age++;
          if (own_req) m_mode = m[4*m_owner +: 4];
        end
      end
      m_cycle = (m_cycle + 1) % (1 << DIV_W);
    end
    g = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    exp_q.push_back({(m_owner >= 0), 2'(m_ptr), m_led1, m_led0, (m_owner >= 0), g});
  endtask

  // driver: apply inputs at negedge, advance model at posedge, compare #1 later
  task automatic step(input logic rst_v, input logic [N-1:0] r, input logic [4*N-1:0] m);
    logic [W-1:0] e;
    @(negedge clk);
    rst_n    = rst_v;
    bus.req  = r;
    bus.mode = m;
    @(posedge clk);
    model_edge(rst_v, r, m);
    #1;
    e = exp_q.pop_front();
    check("grant", 32'(bus.grant), 32'(e[3:0]));
    check("busy",  32'(bus.busy),  32'(e[4]));
    check("led_0", 32'(bus.led_0), 32'(e[5]));
    check("led_1", 32'(bus.led_1), 32'(e[6]));
    check("rr_ptr", 32'(dbg_rr),   32'(e[8:7]));
    check("state", 32'(dbg_state), 32'(e[9]));
  endtask

  logic [N-1:0]   r_cur;
  logic [4*N-1:0] m_cur;

  initial begin
    bus.req  = '0;
    bus.mode = '0;

    // reset with every requester asserted; requester 0 wins first
    for (int i = 0; i < 3; i++) step(1'b0, 4'b1111, 16'h1111);
    for (int i = 0; i < 3; i++) step(1'b1, 4'b1111, 16'h1111);
    for (int i = 0; i < 12; i++) step(1'b1, 4'b0000, 16'h0000);

    // requester 2 alone with mixed blink modes
    for (int i = 0; i < 24; i++) step(1'b1, 4'b0100, 16'h0E00);
    for (int i = 0; i < 6; i++) step(1'b1, 4'b0000, 16'h0000);

    // one-cycle pulse from requester 1: held for the minimum time
    step(1'b1, 4'b0010, 16'h0050);
    for (int i = 0; i < 8; i++) step(1'b1, 4'b0000, 16'h0000);

    // requesters 0 and 3 both held: preemption rotates every MAX_H cycles
    for (int i = 0; i < 35; i++) step(1'b1, 4'b1001, 16'h7001);
    for (int i = 0; i < 14; i++) step(1'b1, 4'b0000, 16'h0000);

    // owner 0 drops exactly as requester 1 raises, after the minimum hold
    for (int i = 0; i < 6; i++) step(1'b1, 4'b0001, 16'h0003);
    for (int i = 0; i < 8; i++) step(1'b1, 4'b0010, 16'h0020);

    // reset in the middle of an ownership
    step(1'b0, 4'b0010, 16'h0020);
    for (int i = 0; i < 4; i++) step(1'b1, 4'b0100, 16'h0100);
    for (int i = 0; i < 6; i++) step(1'b1, 4'b0000, 16'h0000);

    // random phase: slowly changing request levels and modes, rare resets
    r_cur = '0;
    m_cur = '0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) r_cur[$urandom_range(0, N-1)] ^= 1'b1;
      if ($urandom_range(0, 9) == 0) m_cur = 16'($urandom);
      step(($urandom_range(0, 299) != 0), r_cur, m_cur);
    end

    if (exp_q.size() != 0) check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
